// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I core: PC generation against a synchronous-read
// instruction memory, the IF/ID pipeline register, and sticky status/perf counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic [6:0]  if_id_opcode_o,
  output logic [4:0]  if_id_rd_o,
  output logic [4:0]  if_id_rs1_o,
  output logic [4:0]  if_id_rs2_o,
  output logic        misalign_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
);

  // pc_q is the address whose instruction is on imem_rdata_i; fv_q says that data is real.
  logic [31:0] pc_q;
  logic        fv_q;
  logic [31:0] pc_next;
  logic [31:0] tgt;
  logic        eff_flush;
  logic        misalign_hit;

  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  always_comb begin
    tgt          = {branch_target_i[31:2], 2'b00};
    eff_flush    = flush_i | branch_taken_i;
    misalign_hit = branch_taken_i & (|branch_target_i[1:0]);
    pc_next      = pc_q + 32'd4;
    if (branch_taken_i) begin
      pc_next = tgt;
    end else if (stall_i || !fv_q) begin
      // Re-reading the same address keeps imem_rdata_i stable while held.
      pc_next = pc_q;
    end
  end

  // The memory must see RESET_PC throughout reset, whatever the redirect inputs do.
  assign imem_addr_o = reset ? RESET_PC : pc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      fv_q <= 1'b0;
    end else begin
      pc_q <= pc_next;
      fv_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_pc    <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (eff_flush) begin
      // Squash wins over stall; the PC field is left as is.
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall_i) begin
      if_id_pc    <= pc_q;
      if_id_instr <= imem_rdata_i;
      if_id_valid <= fv_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign  <= 1'b0;
      fetch_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      misalign <= misalign | misalign_hit;
      if (!eff_flush && !stall_i && fv_q) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (eff_flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign if_id_pc_o     = if_id_pc;
  assign if_id_pc4_o    = if_id_pc + 32'd4;
  assign if_id_instr_o  = if_id_valid ? if_id_instr : NOP_INSTR;
  assign if_id_valid_o  = if_id_valid;
  assign if_id_opcode_o = if_id_instr_o[6:0];
  assign if_id_rd_o     = if_id_instr_o[11:7];
  assign if_id_rs1_o    = if_id_instr_o[19:15];
  assign if_id_rs2_o    = if_id_instr_o[24:20];
  assign misalign_o     = misalign;
  assign fetch_cnt_o    = fetch_cnt;
  assign flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset checks, then a random
// run compared against a transaction-level model of the fetch stream.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic [6:0]  if_id_opcode_o;
  logic [4:0]  if_id_rd_o;
  logic [4:0]  if_id_rs1_o;
  logic [4:0]  if_id_rs2_o;
  logic        misalign_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] flush_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .if_id_pc_o(if_id_pc_o), .if_id_pc4_o(if_id_pc4_o),
    .if_id_instr_o(if_id_instr_o), .if_id_valid_o(if_id_valid_o),
    .if_id_opcode_o(if_id_opcode_o), .if_id_rd_o(if_id_rd_o),
    .if_id_rs1_o(if_id_rs1_o), .if_id_rs2_o(if_id_rs2_o),
    .misalign_o(misalign_o), .fetch_cnt_o(fetch_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory with a recognisable content pattern.
  always @(posedge clk) imem_rdata_i <= imem_addr_o ^ KEY;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] fc;
    logic [31:0] flc;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic rst, input logic stall, input logic flush, input logic br,
                      input logic [31:0] tgt, input logic [31:0] addr, input logic valid,
                      input logic [31:0] pc, input logic [31:0] fc, input logic [31:0] flc,
                      input logic mis);
    vec_t v;
    v.rst = rst; v.stall = stall; v.flush = flush; v.br = br; v.tgt = tgt;
    v.addr = addr; v.valid = valid; v.pc = pc; v.fc = fc; v.flc = flc; v.mis = mis;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] t);
    stall_i = s; flush_i = f; branch_taken_i = b; branch_target_i = t;
  endtask

  task automatic check_ifid(input string tag, input logic valid, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [31:0] fc,
                            input logic [31:0] flc, input logic mis);
    logic [31:0] ei;
    ei = valid ? instr : NOP;
    chk({tag, " valid"}, {31'd0, if_id_valid_o}, {31'd0, valid});
    chk({tag, " instr"}, if_id_instr_o, ei);
    chk({tag, " opcode"}, {25'd0, if_id_opcode_o}, {25'd0, ei[6:0]});
    chk({tag, " rd"}, {27'd0, if_id_rd_o}, {27'd0, ei[11:7]});
    chk({tag, " rs1"}, {27'd0, if_id_rs1_o}, {27'd0, ei[19:15]});
    chk({tag, " rs2"}, {27'd0, if_id_rs2_o}, {27'd0, ei[24:20]});
    if (valid) begin
      chk({tag, " pc"}, if_id_pc_o, pc);
      chk({tag, " pc4"}, if_id_pc4_o, pc + 32'd4);
    end
    chk({tag, " fetch_cnt"}, fetch_cnt_o, fc);
    chk({tag, " flush_cnt"}, flush_cnt_o, flc);
    chk({tag, " misalign"}, {31'd0, misalign_o}, {31'd0, mis});
  endtask

  // Asserted half-way between edges; every output must show reset values at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    chk({tag, " rst valid"}, {31'd0, if_id_valid_o}, 32'd0);
    chk({tag, " rst instr"}, if_id_instr_o, NOP);
    chk({tag, " rst pc"}, if_id_pc_o, 32'd0);
    chk({tag, " rst pc4"}, if_id_pc4_o, 32'd4);
    chk({tag, " rst misalign"}, {31'd0, misalign_o}, 32'd0);
    chk({tag, " rst fetch_cnt"}, fetch_cnt_o, 32'd0);
    chk({tag, " rst flush_cnt"}, flush_cnt_o, 32'd0);
    chk({tag, " rst addr"}, imem_addr_o, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0044);
    #1;
    chk({tag, " rst addr w/ branch"}, imem_addr_o, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Transaction-level reference: the address memory holds, whether it is real,
  // and the IF/ID contents; instructions follow from the memory pattern.
  logic [31:0] m_pc, m_ifpc, m_fc, m_flc;
  logic        m_ok, m_valid, m_mis;

  initial begin
    // Segment A: start-up, free run, redirects, stall+redirect, misaligned target, plain flush.
    addv(1, 0,0,0, 32'h0,   32'h00,  0, 32'h00,  0, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h04,  1, 32'h00,  1, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h08,  1, 32'h04,  2, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h0C,  1, 32'h08,  3, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h10,  1, 32'h0C,  4, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h14,  1, 32'h10,  5, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h18,  1, 32'h14,  6, 0, 0);
    addv(0, 0,1,1, 32'h100, 32'h100, 0, 32'h0,   6, 1, 0);
    addv(0, 0,0,0, 32'h0,   32'h104, 1, 32'h100, 7, 1, 0);
    addv(0, 0,0,0, 32'h0,   32'h108, 1, 32'h104, 8, 1, 0);
    addv(0, 1,0,1, 32'h40,  32'h40,  0, 32'h0,   8, 2, 0);
    addv(0, 0,0,0, 32'h0,   32'h44,  1, 32'h40,  9, 2, 0);
    addv(0, 0,0,1, 32'h202, 32'h200, 0, 32'h0,   9, 3, 1);
    addv(0, 0,0,0, 32'h0,   32'h204, 1, 32'h200, 10, 3, 1);
    addv(0, 0,0,1, 32'h80,  32'h80,  0, 32'h0,   10, 4, 1);
    addv(0, 0,0,0, 32'h0,   32'h84,  1, 32'h80,  11, 4, 1);
    addv(0, 0,1,0, 32'h0,   32'h88,  0, 32'h0,   11, 5, 1);
    addv(0, 0,0,0, 32'h0,   32'h8C,  1, 32'h88,  12, 5, 1);
    // Segment B: three-cycle stall while IF/ID holds 0x8.
    addv(1, 0,0,0, 32'h0,   32'h00,  0, 32'h00,  0, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h04,  1, 32'h00,  1, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h08,  1, 32'h04,  2, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h0C,  1, 32'h08,  3, 0, 0);
    addv(0, 1,0,0, 32'h0,   32'h0C,  1, 32'h08,  3, 0, 0);
    addv(0, 1,0,0, 32'h0,   32'h0C,  1, 32'h08,  3, 0, 0);
    addv(0, 1,0,0, 32'h0,   32'h0C,  1, 32'h08,  3, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h10,  1, 32'h0C,  4, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h14,  1, 32'h10,  5, 0, 0);
    // Segment C: mid-stream reset, start-up must repeat exactly.
    addv(1, 0,0,0, 32'h0,   32'h00,  0, 32'h00,  0, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h04,  1, 32'h00,  1, 0, 0);
    addv(0, 0,0,0, 32'h0,   32'h08,  1, 32'h04,  2, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].rst) do_reset(tag);
      drive(vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt);
      #1;
      chk({tag, " addr"}, imem_addr_o, vecs[i].addr);
      @(posedge clk);
      #1;
      check_ifid(tag, vecs[i].valid, vecs[i].pc, vecs[i].pc ^ KEY,
                 vecs[i].fc, vecs[i].flc, vecs[i].mis);
      $display("vec%0d stall=%0d flush=%0d br=%0d tgt=%h -> addr=%h valid=%0d pc=%h instr=%h",
               i, vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt,
               imem_addr_o, if_id_valid_o, if_id_pc_o, if_id_instr_o);
    end

    // Random phase against the reference model.
    do_reset("rand");
    m_pc = 32'd0; m_ok = 1'b0; m_valid = 1'b0; m_ifpc = 32'd0;
    m_fc = 32'd0; m_flc = 32'd0; m_mis = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic s, f, b;
      logic [31:0] t, exp_addr;
      string tag;
      tag = $sformatf("rand%0d", c);
      s = ($urandom_range(3) == 0);
      f = ($urandom_range(9) == 0);
      b = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0: t = 32'hFFFF_FFF8 | 32'($urandom_range(7));
        1: t = $urandom;
        default: t = {$urandom_range(32'h3FFF), 2'b00};
      endcase
      drive(s, f, b, t);
      if (b) exp_addr = t & 32'hFFFF_FFFC;
      else if (s || !m_ok) exp_addr = m_pc;
      else exp_addr = m_pc + 32'd4;
      #1;
      chk({tag, " addr"}, imem_addr_o, exp_addr);
      @(posedge clk);
      if (b || f) begin
        m_valid = 1'b0;
        m_flc++;
      end else if (!s) begin
        m_valid = m_ok;
        m_ifpc = m_pc;
        if (m_ok) m_fc++;
      end
      if (b && (t[1:0] != 2'b00)) m_mis = 1'b1;
      m_pc = exp_addr;
      m_ok = 1'b1;
      #1;
      check_ifid(tag, m_valid, m_ifpc, m_ifpc ^ KEY, m_fc, m_flc, m_mis);
      $display("rand%0d s=%0d f=%0d b=%0d t=%h -> valid=%0d pc=%h fc=%0d flc=%0d mis=%0d",
               c, s, f, b, t, if_id_valid_o, if_id_pc_o, fetch_cnt_o, flush_cnt_o, misalign_o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
